// File: rtl/uart_tx.sv
// uart_tx - memory-mapped 8N1 UART transmitter.
//
// Bytes written by the CPU are queued in a small FIFO and shifted out LSB
// first on uart_txd. Each bit lasts div clocks, where div is programmable.
// A level interrupt reports "everything sent".
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   uart_valid          one request per cycle it is high
//   uart_instr          fetch flag, treated as an ordinary read
//   uart_addr[3:2]      register select: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 CTRL
//   uart_wdata/wstrb    write data and byte strobes (wstrb==0 is a read)
//   uart_rdata/ready    registered response, one cycle after each request
//   uart_txd            serial line, idle high
//   uart_irq            irq_en & FIFO empty & transmitter idle
module uart_tx #(
  parameter int fifo_depth_log = 3,
  parameter int div_default    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd,
  output logic        uart_irq
);

  localparam int depth = 1 << fifo_depth_log;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage; no reset so it maps onto distributed/block RAM.
  logic [7:0] mem [depth];

  logic [fifo_depth_log-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [fifo_depth_log:0]   count_reg, count_next;
  state_t                    state_reg, state_next;
  logic [7:0]                shift_reg, shift_next;
  logic [2:0]                bit_idx_reg, bit_idx_next;
  logic [15:0]               bit_cnt_reg, bit_cnt_next;
  logic [15:0]               act_div_reg, act_div_next;
  logic [15:0]               div_reg, div_next;
  logic                      irq_en_reg, irq_en_next;
  logic                      ovf_reg, ovf_next;
  logic                      ready_reg;
  logic [31:0]               rdata_reg, rdata_next;
  logic                      irq_reg;

  logic        fifo_empty, fifo_full;
  logic [1:0]  sel;
  logic        is_write, push_req, push_ok, pop, ovf_event, status_rd;
  logic [15:0] eff_div;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{uart_addr[31:4], uart_addr[1:0], uart_wdata[31:16],
                         uart_wstrb[3:2], uart_instr};

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (fifo_depth_log + 1)'(depth));
  assign sel        = uart_addr[3:2];
  assign is_write   = |uart_wstrb;
  assign push_req   = uart_valid && uart_wstrb[0] && (sel == 2'd0);
  assign status_rd  = uart_valid && !is_write && (sel == 2'd1);
  // A divisor of 0 would never let the bit counter expire cleanly.
  assign eff_div    = (div_reg == 16'd0) ? 16'd1 : div_reg;

  // A push into a full FIFO still fits if the FSM pops in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign ovf_event = push_req && fifo_full && !pop;

  // Transmitter FSM; frames start on the pop, which latches byte and divisor.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    bit_cnt_next = bit_cnt_reg;
    act_div_next = act_div_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr_reg];
          act_div_next = eff_div;
          bit_cnt_next = eff_div - 16'd1;
          state_next   = START;
        end
      end
      START: begin
        if (bit_cnt_reg == 16'd0) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          bit_cnt_next = act_div_reg - 16'd1;
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt_reg == 16'd0) begin
          bit_cnt_next = act_div_reg - 16'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt_reg == 16'd0) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop          = 1'b1;
            shift_next   = mem[rd_ptr_reg];
            act_div_next = eff_div;
            bit_cnt_next = eff_div - 16'd1;
            state_next   = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + (fifo_depth_log + 1)'(1);
      2'b01:   count_next = count_reg - (fifo_depth_log + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Register file and read path.
  always_comb begin
    status_word    = '0;
    status_word[0] = fifo_full;
    status_word[1] = fifo_empty;
    status_word[2] = (state_reg != IDLE);
    status_word[3] = ovf_reg;
    // The count field needs one bit more than the pointer so "full" fits.
    status_word[8 +: fifo_depth_log + 1] = count_reg;

    rdata_next = '0;
    if (uart_valid && !is_write) begin
      case (sel)
        2'd1:    rdata_next = status_word;
        2'd2:    rdata_next = {16'd0, div_reg};
        2'd3:    rdata_next = {31'd0, irq_en_reg};
        default: rdata_next = '0;
      endcase
    end

    div_next = div_reg;
    if (uart_valid && (sel == 2'd2)) begin
      if (uart_wstrb[0]) div_next[7:0]  = uart_wdata[7:0];
      if (uart_wstrb[1]) div_next[15:8] = uart_wdata[15:8];
    end

    irq_en_next = irq_en_reg;
    if (uart_valid && (sel == 2'd3) && uart_wstrb[0]) irq_en_next = uart_wdata[0];

    // A fresh overflow wins over the clear-on-read.
    if (ovf_event)      ovf_next = 1'b1;
    else if (status_rd) ovf_next = 1'b0;
    else                ovf_next = ovf_reg;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= uart_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      bit_cnt_reg <= '0;
      act_div_reg <= 16'(div_default);
      div_reg     <= 16'(div_default);
      irq_en_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      rdata_reg   <= '0;
      irq_reg     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + fifo_depth_log'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + fifo_depth_log'(1);
      count_reg   <= count_next;
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      bit_cnt_reg <= bit_cnt_next;
      act_div_reg <= act_div_next;
      div_reg     <= div_next;
      irq_en_reg  <= irq_en_next;
      ovf_reg     <= ovf_next;
      ready_reg   <= uart_valid;
      rdata_reg   <= rdata_next;
      // Built from next-state values so a push or irq_en clear drops it at once.
      irq_reg     <= irq_en_next && (count_next == '0) && (state_next == IDLE);
    end
  end

  assign uart_ready = ready_reg;
  assign uart_rdata = rdata_reg;
  assign uart_irq   = irq_reg;
  assign uart_txd   = (state_reg == START) ? 1'b0 :
                      (state_reg == DATA)  ? shift_reg[bit_idx_reg] : 1'b1;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - directed self-checking bench for uart_tx.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_valid;
  logic        uart_instr;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_txd;
  logic        uart_irq;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] A_TX   = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_DIV  = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  uart_tx #(.fifo_depth_log(3), .div_default(16)) dut (
    .clk(clk), .rst(rst),
    .uart_valid(uart_valid), .uart_instr(uart_instr), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata),
    .uart_ready(uart_ready), .uart_txd(uart_txd), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    uart_valid = 1'b1; uart_instr = 1'b0; uart_addr = a; uart_wdata = d; uart_wstrb = s;
    @(negedge clk);
    uart_valid = 1'b0; uart_wstrb = 4'd0;
    check("wr ready", 32'(uart_ready), 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    uart_valid = 1'b1; uart_instr = 1'b1; uart_addr = a; uart_wstrb = 4'd0;
    @(negedge clk);
    uart_valid = 1'b0; uart_instr = 1'b0;
    check("rd ready", 32'(uart_ready), 32'd1);
    d = uart_rdata;
  endtask

  // Samples txd once per cycle across a whole 10-bit frame.
  // If now=1 the first sample is taken at the current negedge.
  task automatic check_frame(input logic [7:0] b, input int div, input bit now);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < div; k++) begin
        if (!(now && i == 0 && k == 0)) @(negedge clk);
        check($sformatf("frame %02h bit %0d cyc %0d", b, i, k), 32'(uart_txd), 32'(fr[i]));
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rd;
  int          bad;

  initial begin
    rst = 1'b1; uart_valid = 1'b0; uart_instr = 1'b0;
    uart_addr = '0; uart_wdata = '0; uart_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst ready", 32'(uart_ready), 32'd0);
    check("rst rdata", uart_rdata, 32'd0);
    check("rst txd", 32'(uart_txd), 32'd1);
    check("rst irq", 32'(uart_irq), 32'd0);
    bus_read(A_STAT, rd); check("rst status", rd, 32'h2);
    @(negedge clk);
    check("idle ready low", 32'(uart_ready), 32'd0);
    check("idle rdata zero", uart_rdata, 32'd0);
    bus_read(A_DIV, rd); check("rst div", rd, 32'd16);
    bus_read(A_CTRL, rd); check("rst ctrl", rd, 32'd0);

    // Single byte, div=4
    bus_write(A_DIV, 32'd4, 4'b0011);
    bus_write(A_TX, 32'h55, 4'b0001);
    check_frame(8'h55, 4, 1'b0);
    bus_read(A_STAT, rd); check("single status", rd, 32'h2);

    // Strobe-less TXDATA write ignored, TXDATA reads 0
    bus_write(A_TX, 32'h12, 4'b0010);
    bus_read(A_STAT, rd); check("nostrobe status", rd, 32'h2);
    bus_read(A_TX, rd); check("txdata read", rd, 32'd0);

    // Back-to-back frames, div=2
    bus_write(A_DIV, 32'd2, 4'b0011);
    @(negedge clk);
    uart_valid = 1'b1; uart_addr = A_TX; uart_wdata = 32'hA5; uart_wstrb = 4'b0001;
    @(negedge clk);
    check("b2b ready 1", 32'(uart_ready), 32'd1);
    uart_wdata = 32'h3C;
    @(negedge clk);
    uart_valid = 1'b0; uart_wstrb = 4'd0;
    check("b2b ready 2", 32'(uart_ready), 32'd1);
    check_frame(8'hA5, 2, 1'b1);
    check_frame(8'h3C, 2, 1'b0);
    @(negedge clk);
    check("b2b idle txd", 32'(uart_txd), 32'd1);

    // Overflow, div=100
    bus_write(A_DIV, 32'd100, 4'b0011);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_valid = 1'b1; uart_addr = A_TX; uart_wdata = 32'(i + 1); uart_wstrb = 4'b0001;
      @(negedge clk);
      check($sformatf("ovf ready %0d", i), 32'(uart_ready), 32'd1);
    end
    uart_valid = 1'b0; uart_wstrb = 4'd0;
    bus_read(A_STAT, rd); check("ovf status 1", rd, 32'h80D);
    bus_read(A_STAT, rd); check("ovf status 2", rd, 32'h805);
    pulse_reset();
    check("flush txd", 32'(uart_txd), 32'd1);
    bus_read(A_STAT, rd); check("flush status", rd, 32'h2);

    // Divisor change mid-frame
    bus_write(A_DIV, 32'd3, 4'b0011);
    bus_write(A_TX, 32'hFF, 4'b0001);
    fork
      begin
        check_frame(8'hFF, 3, 1'b0);
        check_frame(8'h00, 5, 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        bus_write(A_DIV, 32'd5, 4'b0011);
        bus_write(A_TX, 32'h00, 4'b0001);
      end
    join
    @(negedge clk);
    check("divchg idle txd", 32'(uart_txd), 32'd1);

    // Interrupt
    bus_write(A_DIV, 32'd2, 4'b0011);
    check("irq before en", 32'(uart_irq), 32'd0);
    bus_write(A_CTRL, 32'd1, 4'b0001);
    check("irq on", 32'(uart_irq), 32'd1);
    bus_write(A_TX, 32'h81, 4'b0001);
    check("irq off after push", 32'(uart_irq), 32'd0);
    check_frame(8'h81, 2, 1'b0);
    check("irq in stop", 32'(uart_irq), 32'd0);
    @(negedge clk);
    check("irq after stop", 32'(uart_irq), 32'd1);
    bus_read(A_CTRL, rd); check("ctrl read", rd, 32'd1);
    bus_write(A_CTRL, 32'd0, 4'b0001);
    check("irq cleared", 32'(uart_irq), 32'd0);

    // Divisor 0 acts as 1
    bus_write(A_DIV, 32'd0, 4'b0011);
    bus_write(A_TX, 32'h0F, 4'b0001);
    check_frame(8'h0F, 1, 1'b0);

    // Reset mid-frame with 3 bytes queued
    bus_write(A_DIV, 32'd2, 4'b0011);
    for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h00, 4'b0001);
    bus_read(A_STAT, rd); check("pre-rst status", rd, 32'h304);
    check("pre-rst txd", 32'(uart_txd), 32'd0);
    pulse_reset();
    check("post-rst txd", 32'(uart_txd), 32'd1);
    bus_read(A_STAT, rd); check("post-rst status", rd, 32'h2);
    bus_read(A_DIV, rd); check("post-rst div", rd, 32'd16);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) bad++;
    end
    check("no frames after rst", 32'(bad), 32'd0);

    // Partial divisor strobe
    bus_write(A_DIV, 32'h1234, 4'b0010);
    bus_read(A_DIV, rd); check("div strobe hi", rd, 32'h1210);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
